// File: rtl/idli_sqi_fetch_m.sv
// SQI streaming-read instruction fetch: issues READ 0x03 + 24b address, then
// assembles 16b instructions from successive nibbles for the decode stage.
module idli_sqi_fetch_m #(
    parameter logic [15:0] RESET_ADDR   = 16'h0000,
    parameter int          DUMMY_CYCLES = 2
) (
    input  logic        i_sf_gck,
    input  logic        i_sf_rst_n,
    input  logic        i_sf_redirect,
    input  logic [15:0] i_sf_redirect_addr,
    output logic        o_sf_cs_n,
    output logic        o_sf_sck_en,
    output logic [3:0]  o_sf_sio_out,
    output logic        o_sf_sio_oe,
    input  logic [3:0]  i_sf_sio_in,
    output logic [1:0]  o_sf_ctr,
    output logic [15:0] o_sf_enc,
    output logic        o_sf_enc_vld,
    output logic [15:0] o_sf_addr
);

    typedef logic [1:0]  ctr_t;
    typedef logic [15:0] data_t;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA} state_t;

    // The last dummy cycle overlaps the bus turnaround, so DUMMY holds for
    // DUMMY_CYCLES-1 cycles and DATA nibble 0 lands right after it.
    localparam logic [2:0] DUMMY_LAST = (DUMMY_CYCLES >= 2) ? 3'(DUMMY_CYCLES - 2) : 3'd0;

    state_t      state_q, state_d;
    logic [2:0]  sub_q, sub_d;
    ctr_t        ctr_q, ctr_d;
    logic [11:0] buf_q, buf_d;
    data_t       addr_q, addr_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_en_q, sck_en_d;
    logic        oe_q, oe_d;
    logic [3:0]  sio_out_q, sio_out_d;
    logic [23:0] byte_addr;

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        ctr_d   = ctr_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        if (i_sf_redirect) begin
            state_d = ST_IDLE;
            sub_d   = 3'd0;
            ctr_d   = 2'd0;
            buf_d   = 12'd0;
            addr_d  = i_sf_redirect_addr;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    sub_d   = 3'd0;
                end
                ST_CMD: begin
                    if (sub_q == 3'd1) begin
                        state_d = ST_ADDR;
                        sub_d   = 3'd0;
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end
                ST_ADDR: begin
                    if (sub_q == 3'd5) begin
                        state_d = (DUMMY_CYCLES >= 2) ? ST_DUMMY : ST_DATA;
                        sub_d   = 3'd0;
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end
                ST_DUMMY: begin
                    if (sub_q == DUMMY_LAST) begin
                        state_d = ST_DATA;
                        sub_d   = 3'd0;
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end
                ST_DATA: begin
                    ctr_d = ctr_q + 2'd1;
                    unique case (ctr_q)
                        2'd0: buf_d[3:0]  = i_sf_sio_in;
                        2'd1: buf_d[7:4]  = i_sf_sio_in;
                        2'd2: buf_d[11:8] = i_sf_sio_in;
                        2'd3: addr_d      = addr_q + 16'd1;
                        default: ;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Pin outputs are derived from the next state so they are flops.
    always_comb begin
        byte_addr = {7'b0, addr_d, 1'b0};
        cs_n_d    = (state_d == ST_IDLE);
        sck_en_d  = !cs_n_d;
        oe_d      = (state_d == ST_CMD) || (state_d == ST_ADDR);
        sio_out_d = 4'h0;
        if (state_d == ST_CMD && sub_d == 3'd1) begin
            sio_out_d = 4'h3;
        end else if (state_d == ST_ADDR) begin
            unique case (sub_d)
                3'd0:    sio_out_d = byte_addr[23:20];
                3'd1:    sio_out_d = byte_addr[19:16];
                3'd2:    sio_out_d = byte_addr[15:12];
                3'd3:    sio_out_d = byte_addr[11:8];
                3'd4:    sio_out_d = byte_addr[7:4];
                3'd5:    sio_out_d = byte_addr[3:0];
                default: sio_out_d = 4'h0;
            endcase
        end
    end

    always_ff @(posedge i_sf_gck or negedge i_sf_rst_n) begin
        if (!i_sf_rst_n) begin
            state_q   <= ST_IDLE;
            sub_q     <= 3'd0;
            ctr_q     <= 2'd0;
            buf_q     <= 12'd0;
            addr_q    <= RESET_ADDR;
            cs_n_q    <= 1'b1;
            sck_en_q  <= 1'b0;
            oe_q      <= 1'b0;
            sio_out_q <= 4'h0;
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            ctr_q     <= ctr_d;
            buf_q     <= buf_d;
            addr_q    <= addr_d;
            cs_n_q    <= cs_n_d;
            sck_en_q  <= sck_en_d;
            oe_q      <= oe_d;
            sio_out_q <= sio_out_d;
        end
    end

    assign o_sf_cs_n    = cs_n_q;
    assign o_sf_sck_en  = sck_en_q;
    assign o_sf_sio_oe  = oe_q;
    assign o_sf_sio_out = sio_out_q;
    assign o_sf_ctr     = ctr_q;
    assign o_sf_addr    = addr_q;
    // Top nibble arrives in the ctr==3 cycle itself; it is not flopped.
    assign o_sf_enc     = {i_sf_sio_in, buf_q};
    assign o_sf_enc_vld = (state_q == ST_DATA) && (ctr_q == 2'd3) && !i_sf_redirect;

endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// Bench for idli_sqi_fetch_m: SQI memory slave, cycle-level reference model
// tracked from reset/redirect, and directed plus randomized redirect scenarios.
module tb_idli_sqi_fetch_m;
    localparam int          DC     = 2;
    localparam logic [15:0] RA     = 16'h0000;
    localparam int          FIRST  = 11 + DC;
    localparam int          DSTART = 8 + DC;

    logic        clk = 1'b0, rst_n = 1'b1, redirect = 1'b0;
    logic [15:0] raddr = 16'h0;
    logic [3:0]  sio_in = 4'h0;
    logic        cs_n, sck_en, oe, vld;
    logic [3:0]  sio_out;
    logic [1:0]  ctr;
    logic [15:0] enc, addr;

    int checks = 0, errors = 0;
    int t = 0;
    logic [15:0] start = RA;
    bit mon_en = 1'b0;

    idli_sqi_fetch_m #(.RESET_ADDR(RA), .DUMMY_CYCLES(DC)) dut (
        .i_sf_gck(clk), .i_sf_rst_n(rst_n), .i_sf_redirect(redirect),
        .i_sf_redirect_addr(raddr), .o_sf_cs_n(cs_n), .o_sf_sck_en(sck_en),
        .o_sf_sio_out(sio_out), .o_sf_sio_oe(oe), .i_sf_sio_in(sio_in),
        .o_sf_ctr(ctr), .o_sf_enc(enc), .o_sf_enc_vld(vld), .o_sf_addr(addr));

    always #5 clk = ~clk;

    // Memory contents: word w, nibble k.
    function automatic logic [15:0] mem_word(input logic [15:0] w);
        logic [15:0] r;
        for (int k = 0; k < 4; k++)
            r[4*k +: 4] = 4'((32'(w) * 4) + k + 1 + 5 * (32'(w) >> 4));
        return r;
    endfunction

    // Reference model: cycles since the fetch restarted and the restart address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= 0; start <= RA;
        end else if (redirect) begin
            t <= 0; start <= raddr;
        end else begin
            t <= t + 1;
        end
    end

    // SQI slave: counts clocked nibbles while selected, captures address, streams data.
    int nib_cnt = 0;
    logic [23:0] sa = 24'h0;
    always @(posedge clk) begin
        if (!rst_n || cs_n) nib_cnt <= 0;
        else begin
            if (nib_cnt >= 2 && nib_cnt < 8) sa <= {sa[19:0], sio_out};
            nib_cnt <= nib_cnt + 1;
        end
    end

    int sd;
    logic [15:0] sw, swd;
    always @(posedge clk) begin
        #2;
        if (!cs_n && nib_cnt >= DSTART - 1) begin
            sd = nib_cnt - (DSTART - 1);
            sw = sa[16:1] + 16'(sd / 4);
            swd = mem_word(sw);
            sio_in = swd[4*(sd%4) +: 4];
        end else begin
            sio_in = 4'($urandom);
        end
    end

    // Scoreboard: every cycle compare all pins against the model.
    int k_m;
    logic e_cs, e_oe, e_vld;
    logic [1:0] e_ctr;
    logic [15:0] e_addr;
    logic [3:0] e_sio;
    logic [23:0] e_ba;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                checks++;
                if ({cs_n, sck_en, oe, ctr, vld, addr} !== {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, RA}) begin
                    errors++;
                    $display("FAIL mon_reset got cs=%b sck=%b oe=%b ctr=%0d vld=%b addr=%h", cs_n, sck_en, oe, ctr, vld, addr);
                end
            end else begin
                k_m    = t - DSTART;
                e_cs   = (t == 0);
                e_oe   = (t >= 1 && t <= 8);
                e_ctr  = (k_m >= 0) ? 2'(k_m % 4) : 2'd0;
                e_addr = start + ((k_m >= 0) ? 16'(k_m / 4) : 16'd0);
                e_vld  = (k_m >= 0) && (k_m % 4 == 3) && !redirect;
                e_ba   = {7'b0, start, 1'b0};
                e_sio  = (t == 2) ? 4'h3 : (t >= 3 && t <= 8) ? 4'(e_ba >> (4 * (8 - t))) : 4'h0;
                checks++;
                if (cs_n !== e_cs || sck_en !== !e_cs) begin
                    errors++; $display("FAIL mon_cs t=%0d got cs=%b sck=%b want cs=%b", t, cs_n, sck_en, e_cs);
                end
                checks++;
                if (oe !== e_oe) begin
                    errors++; $display("FAIL mon_oe t=%0d got %b want %b", t, oe, e_oe);
                end
                checks++;
                if (ctr !== e_ctr) begin
                    errors++; $display("FAIL mon_ctr t=%0d got %0d want %0d", t, ctr, e_ctr);
                end
                checks++;
                if (addr !== e_addr) begin
                    errors++; $display("FAIL mon_addr t=%0d got %h want %h", t, addr, e_addr);
                end
                checks++;
                if (vld !== e_vld) begin
                    errors++; $display("FAIL mon_vld t=%0d got %b want %b", t, vld, e_vld);
                end
                if (e_vld) begin
                    checks++;
                    if (enc !== mem_word(e_addr)) begin
                        errors++; $display("FAIL mon_enc t=%0d got %h want %h", t, enc, mem_word(e_addr));
                    end
                end
                if (e_oe) begin
                    checks++;
                    if (sio_out !== e_sio) begin
                        errors++; $display("FAIL mon_sio t=%0d got %h want %h", t, sio_out, e_sio);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_redirect(input logic [15:0] a);
        redirect = 1'b1; raddr = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] sio_seq [0:8];
        logic cs_seq [0:13];
        logic oe_seq [0:13];
        logic vld_seq [0:17];
        logic [3:0] want_sio [0:8];
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({cs_n, sck_en, oe, sio_out, ctr, vld, addr} !== {1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, RA}) begin
            errors++; $display("FAIL reset_vals got cs=%b sck=%b oe=%b sio=%h ctr=%0d vld=%b addr=%h", cs_n, sck_en, oe, sio_out, ctr, vld, addr);
        end
        mon_en = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        want_sio = '{4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c <= 8) sio_seq[c] = sio_out;
            if (c <= 13) begin cs_seq[c] = cs_n; oe_seq[c] = oe; end
            vld_seq[c] = vld;
            if (c == 13) begin
                checks++;
                if (enc !== 16'h4321 || addr !== 16'h0000 || ctr !== 2'd3) begin
                    errors++; $display("FAIL word0 got enc=%h addr=%h ctr=%0d want 4321/0000/3", enc, addr, ctr);
                end
            end
            if (c == 17) begin
                checks++;
                if (enc !== 16'h8765 || addr !== 16'h0001) begin
                    errors++; $display("FAIL word1 got enc=%h addr=%h want 8765/0001", enc, addr);
                end
            end
        end
        checks++;
        if (cs_seq[0] !== 1'b1 || cs_seq[1] !== 1'b0) begin
            errors++; $display("FAIL cs_fall got c0=%b c1=%b want 1,0", cs_seq[0], cs_seq[1]);
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (sio_seq[c] !== want_sio[c]) begin
                errors++; $display("FAIL cmd_addr_seq c=%0d got %h want %h", c, sio_seq[c], want_sio[c]);
            end
        end
        checks++;
        if (oe_seq[8] !== 1'b1 || oe_seq[9] !== 1'b0) begin
            errors++; $display("FAIL oe_drop got c8=%b c9=%b want 1,0", oe_seq[8], oe_seq[9]);
        end
        for (int c = 0; c <= 17; c++) begin
            checks++;
            if (vld_seq[c] !== (c == FIRST || c == FIRST + 4)) begin
                errors++; $display("FAIL vld_timing c=%0d got %b want %b", c, vld_seq[c], (c == FIRST || c == FIRST + 4));
            end
        end
    endtask

    task automatic test_redirect_ctr3();
        int n;
        logic [3:0] nib [0:5];
        logic [3:0] want [0:5];
        bit found;
        n = 0;
        while (ctr !== 2'd2 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (ctr !== 2'd2) begin errors++; $display("FAIL rd3_wait got ctr=%0d want 2", ctr); end
        @(posedge clk); #1;
        redirect = 1'b1; raddr = 16'h1234;
        @(negedge clk);
        checks++;
        if (vld !== 1'b0 || ctr !== 2'd3) begin
            errors++; $display("FAIL rd3_suppress got vld=%b ctr=%0d want 0/3", vld, ctr);
        end
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (cs_n !== 1'b1) begin errors++; $display("FAIL rd3_cs got %b want 1", cs_n); end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 3) nib[c-3] = sio_out;
        end
        want = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (nib[i] !== want[i]) begin errors++; $display("FAIL rd3_addr_nib i=%0d got %h want %h", i, nib[i], want[i]); end
        end
        found = 1'b0;
        for (int c = 9; c <= FIRST + 2 && !found; c++) begin
            @(negedge clk);
            if (vld) begin
                found = 1'b1;
                checks++;
                if (c !== FIRST || addr !== 16'h1234 || enc !== mem_word(16'h1234)) begin
                    errors++; $display("FAIL rd3_word got c=%0d addr=%h enc=%h want %0d/1234/%h", c, addr, enc, FIRST, mem_word(16'h1234));
                end
            end
        end
        if (!found) begin errors++; checks++; $display("FAIL rd3_timeout got no vld want vld"); end
    endtask

    task automatic test_double_redirect();
        logic [15:0] a, b, c;
        int nv, first_c;
        logic [15:0] first_addr;
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
        pulse_redirect(a);
        repeat (4) tick();
        pulse_redirect(b);
        tick();
        pulse_redirect(c);
        nv = 0; first_c = -1; first_addr = 16'h0;
        for (int i = 0; i <= FIRST + 1; i++) begin
            @(negedge clk);
            if (vld) begin
                nv++;
                if (first_c < 0) begin first_c = i; first_addr = addr; end
            end
        end
        checks++;
        if (nv !== 1 || first_c !== FIRST || first_addr !== c) begin
            errors++; $display("FAIL double_redir got n=%0d c=%0d addr=%h want 1/%0d/%h", nv, first_c, first_addr, FIRST, c);
        end
    endtask

    task automatic test_wrap();
        int cs_high;
        pulse_redirect(16'hFFFF);
        cs_high = 0;
        for (int i = 0; i <= FIRST + 4; i++) begin
            @(negedge clk);
            if (i >= 1 && cs_n !== 1'b0) cs_high++;
            if (i == FIRST) begin
                checks++;
                if (!vld || addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_w0 got vld=%b addr=%h want 1/ffff", vld, addr); end
            end
            if (i == FIRST + 4) begin
                checks++;
                if (!vld || addr !== 16'h0000 || enc !== mem_word(16'h0000)) begin
                    errors++; $display("FAIL wrap_w1 got vld=%b addr=%h enc=%h want 1/0000/%h", vld, addr, enc, mem_word(16'h0000));
                end
            end
        end
        checks++;
        if (cs_high !== 0) begin errors++; $display("FAIL wrap_cs got %0d high cycles want 0", cs_high); end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (ctr !== 2'd1 && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_n, sck_en, oe, vld, ctr, addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, RA}) begin
            errors++; $display("FAIL async_rst got cs=%b sck=%b oe=%b vld=%b ctr=%0d addr=%h", cs_n, sck_en, oe, vld, ctr, addr);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i <= FIRST; i++) begin
            @(negedge clk);
            if (i == FIRST) begin
                checks++;
                if (!vld || addr !== RA || enc !== mem_word(RA)) begin
                    errors++; $display("FAIL async_restart got vld=%b addr=%h enc=%h want 1/%h/%h", vld, addr, enc, RA, mem_word(RA));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        bit found;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(30, 0)) tick();
            a = 16'($urandom);
            redirect = 1'b1; raddr = a;
            if ($urandom_range(3, 0) == 0) begin
                tick();
                a = 16'($urandom); raddr = a;
            end
            tick();
            redirect = 1'b0;
        end
        found = 1'b0;
        for (int i = 0; i <= FIRST + 2 && !found; i++) begin
            @(negedge clk);
            if (vld) begin
                found = 1'b1;
                checks++;
                if (i !== FIRST || addr !== a || enc !== mem_word(a)) begin
                    errors++; $display("FAIL rand_last got c=%0d addr=%h enc=%h want %0d/%h/%h", i, addr, enc, FIRST, a, mem_word(a));
                end
            end
        end
        if (!found) begin errors++; checks++; $display("FAIL rand_timeout got no vld want vld"); end
    endtask

    initial begin
        test_reset();
        test_redirect_ctr3();
        test_double_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
